xor_sample_sequencer: RTL
=========================

# xor_sample_sequencer

Control stage between the Qsys FIFO Avalon-MM ports (cpu2fpga read side, fpga2cpu write side) and the XOR perceptron datapath (in_layer → mid_layer → out_layer). Replaces free-running poll timing with a handshake-correct sequencer. Each sample is fetched under waitrequest, held stable for the datapath's fixed compute latency, and followed by a one-cycle weight-update strobe. The datapath result is then written back through the output FIFO under waitrequest.

## Interface
Parameters:
- DATA_W, 32, FIFO word and sample width
- CALC_LAT, 16, cycles the perceptron datapath needs from a stable input to a valid result/new weights (≥1)
- POLL_GAP, 1000, idle cycles between end of a write and the next read (≥1)
- CNT_W, 16, width of sample counter

Ports:
- iCLK  in  1  system clock, all logic on rising edge
- iRESET_  in  1  asynchronous active-low reset
- oFIFO_RD  out  1  Avalon read, cpu2fpga FIFO
- iFIFO_RDDATA  in  DATA_W  Avalon readdata
- iFIFO_RD_WAIT  in  1  Avalon waitrequest, read side
- oFIFO_WR  out  1  Avalon write, fpga2cpu FIFO
- oFIFO_WRDATA  out  DATA_W  Avalon writedata
- iFIFO_WR_WAIT  in  1  Avalon waitrequest, write side
- oDATA  out  DATA_W  sample to in_layer, held between fetches
- oDATA_VALID  out  1  one-cycle pulse, first cycle oDATA carries a new sample
- iRESULT  in  DATA_W  out_layer output
- oUPDATE  out  1  one-cycle weight-register load enable
- oSAMPLE_CNT  out  CNT_W  completed samples (write accepted)
- oBUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, READ, CALC, UPDATE, WRITE.
- IDLE: the gap counter increments each cycle. On reaching POLL_GAP-1, the counter clears and the block enters READ.
- READ: oFIFO_RD=1 and is held while iFIFO_RD_WAIT=1. A transfer completes in the cycle with oFIFO_RD & !iFIFO_RD_WAIT.
  - On completion, capture into oDATA, pulse oDATA_VALID next cycle, enter CALC.
  - Sentinel: readdata 32'hFFFFFFFF is captured as 32'h10000001. All other values are captured unchanged, including 0.
- CALC: the latency counter runs 0..CALC_LAT-1. On the last count, enter UPDATE.
- UPDATE: oUPDATE=1 for exactly one cycle. iRESULT is registered into oFIFO_WRDATA in the same cycle. Enter WRITE.
- WRITE: oFIFO_WR=1 with oFIFO_WRDATA stable, held while iFIFO_WR_WAIT=1.
  - On the accepting cycle (write & !wait): oSAMPLE_CNT+1 (wraps modulo 2^CNT_W), enter IDLE.
- oDATA changes only on a completed read. It stays stable through CALC, UPDATE, WRITE and IDLE.
- No other transitions. Exactly one read and one write per sample.

## Timing
- Reset (async assert, registered deassert not required inside block): state=IDLE, all counters 0, oFIFO_RD=0, oFIFO_WR=0, oFIFO_WRDATA=0, oDATA=0, oDATA_VALID=0, oUPDATE=0, oSAMPLE_CNT=0, oBUSY=0.
- Reset mid-operation: all of the above take effect immediately. Any outstanding read or write is abandoned, with no completion and no count.
- First read is asserted POLL_GAP cycles after reset release.
- With zero waitrequest: READ 1 cycle, CALC CALC_LAT cycles, UPDATE 1, WRITE 1, IDLE POLL_GAP. Period = POLL_GAP+CALC_LAT+3 cycles.
- oDATA_VALID is high in the first CALC cycle. oUPDATE is high exactly CALC_LAT cycles after oDATA_VALID.
- Waitrequest stretches READ/WRITE indefinitely. No timeout. Command outputs and writedata stay stable while stalled.
- oFIFO_RD and oFIFO_WR are never high in the same cycle.

## Test plan
- Reset/idle: hold iRESET_=0, then release. All outputs are 0; oFIFO_RD first rises exactly POLL_GAP cycles after release. Assert iRESET_ again mid-CALC; all outputs return to 0 immediately.
- Basic sample: readdata 32'h10000000, no wait, iRESULT=32'h3F800000. Checks:
  - oDATA=32'h10000000 with a single oDATA_VALID pulse.
  - oUPDATE one cycle, CALC_LAT cycles later.
  - oFIFO_WRDATA=32'h3F800000 written once; oSAMPLE_CNT=1.
  - Total period POLL_GAP+CALC_LAT+3.
- Sentinel: readdata 32'hFFFFFFFF → oDATA=32'h10000001. Readdata 32'h00000000 → oDATA=0.
- Read stall: iFIFO_RD_WAIT high 5 cycles with readdata changing. oFIFO_RD is held 6 cycles; only the value on the !wait cycle is captured; oDATA is unchanged before that.
- Write stall: iFIFO_WR_WAIT high 7 cycles while iRESULT changes after UPDATE. oFIFO_WRDATA stays at the UPDATE-cycle value; oSAMPLE_CNT increments once, on acceptance only.
- Counter wrap: CNT_W=4, run 17 samples → oSAMPLE_CNT=1. Across all samples, oFIFO_RD and oFIFO_WR are never both high.

Source files
------------

// File: rtl/xor_sample_sequencer_if.sv
// xor_sample_sequencer_if
//
// Avalon-MM handshake bundle between the sequencer and the two Qsys FIFOs.
// The signal names are written from the sequencer's point of view (o = driven
// by the sequencer, i = driven by the FIFOs).
//
//   oFIFO_RD       read strobe, cpu2fpga FIFO
//   iFIFO_RDDATA   readdata from cpu2fpga FIFO
//   iFIFO_RD_WAIT  waitrequest, read side
//   oFIFO_WR       write strobe, fpga2cpu FIFO
//   oFIFO_WRDATA   writedata to fpga2cpu FIFO
//   iFIFO_WR_WAIT  waitrequest, write side
//
// Modports: master = sequencer side, slave = FIFO side.
interface xor_sample_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              oFIFO_RD;
  logic [DATA_W-1:0] iFIFO_RDDATA;
  logic              iFIFO_RD_WAIT;
  logic              oFIFO_WR;
  logic [DATA_W-1:0] oFIFO_WRDATA;
  logic              iFIFO_WR_WAIT;

  modport master (
    output oFIFO_RD,
    input  iFIFO_RDDATA,
    input  iFIFO_RD_WAIT,
    output oFIFO_WR,
    output oFIFO_WRDATA,
    input  iFIFO_WR_WAIT
  );

  modport slave (
    input  oFIFO_RD,
    output iFIFO_RDDATA,
    output iFIFO_RD_WAIT,
    input  oFIFO_WR,
    input  oFIFO_WRDATA,
    output iFIFO_WR_WAIT
  );
endinterface

// File: rtl/xor_sample_sequencer.sv
// xor_sample_sequencer
//
// Control stage between the Qsys FIFO Avalon-MM ports and the XOR perceptron
// datapath. Each sample is fetched from the cpu2fpga FIFO under waitrequest,
// held stable on oDATA while the datapath computes for CALC_LAT cycles, then a
// one-cycle weight-update strobe is issued and the datapath result is written
// back to the fpga2cpu FIFO under waitrequest. POLL_GAP idle cycles separate
// the end of a write from the next read.
//
// Ports:
//   iCLK         system clock, rising edge
//   iRESET_      asynchronous active-low reset
//   fifo         Avalon read/write handshake bundle (master modport)
//   oDATA        current sample to in_layer, changes only on a completed read
//   oDATA_VALID  one-cycle pulse in the first cycle oDATA holds a new sample
//   iRESULT      out_layer result, sampled during the UPDATE cycle
//   oUPDATE      one-cycle weight-register load enable
//   oSAMPLE_CNT  number of samples whose write was accepted (wraps)
//   oBUSY        high whenever the sequencer is not idle
//
// All outputs are registered.
module xor_sample_sequencer #(
  parameter int DATA_W   = 32,
  parameter int CALC_LAT = 16,
  parameter int POLL_GAP = 1000,
  parameter int CNT_W    = 16
) (
  input  logic                  iCLK,
  input  logic                  iRESET_,
  xor_sample_sequencer_if.master fifo,
  output logic [DATA_W-1:0]     oDATA,
  output logic                  oDATA_VALID,
  input  logic [DATA_W-1:0]     iRESULT,
  output logic                  oUPDATE,
  output logic [CNT_W-1:0]      oSAMPLE_CNT,
  output logic                  oBUSY
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam int LAT_W = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;

  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(CALC_LAT - 1);

  // The host uses all-ones as an in-band marker; the datapath expects this
  // fixed encoding in its place.
  localparam logic [DATA_W-1:0] SENTINEL_IN  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] SENTINEL_OUT = DATA_W'(32'h1000_0001);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CALC,
    UPDATE,
    WRITE
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              update_q, update_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // Next-state and next-output logic. Command strobes are computed one cycle
  // ahead so that every output comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    lat_d    = lat_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wrdata_d = wrdata_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    update_d = 1'b0;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          rd_d    = 1'b1;
          state_d = READ;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      READ: begin
        // Readdata is only meaningful on the cycle waitrequest is low.
        if (rd_q && !fifo.iFIFO_RD_WAIT) begin
          rd_d    = 1'b0;
          data_d  = (fifo.iFIFO_RDDATA == SENTINEL_IN) ? SENTINEL_OUT
                                                       : fifo.iFIFO_RDDATA;
          valid_d = 1'b1;
          lat_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        if (lat_q == LAT_LAST) begin
          lat_d    = '0;
          update_d = 1'b1;
          state_d  = UPDATE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      UPDATE: begin
        // Capture the result here so writedata stays stable however long the
        // output FIFO stalls, even though the datapath output may move on.
        wrdata_d = iRESULT;
        wr_d     = 1'b1;
        state_d  = WRITE;
      end

      WRITE: begin
        if (wr_q && !fifo.iFIFO_WR_WAIT) begin
          wr_d    = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any outstanding transfer.
  always_ff @(posedge iCLK or negedge iRESET_) begin
    if (!iRESET_) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      lat_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wrdata_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      lat_q    <= lat_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wrdata_q <= wrdata_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign fifo.oFIFO_RD     = rd_q;
  assign fifo.oFIFO_WR     = wr_q;
  assign fifo.oFIFO_WRDATA = wrdata_q;
  assign oDATA             = data_q;
  assign oDATA_VALID       = valid_q;
  assign oUPDATE           = update_q;
  assign oSAMPLE_CNT       = cnt_q;
  assign oBUSY             = busy_q;

endmodule
